// File: rtl/k_8_square_seq_if.sv
// rtl/k_8_square_seq_if.sv - operand/result handshake bundle for the FP16 squarer
interface k_8_square_seq_if;
    logic [15:0] in;
    logic        en;
    logic [15:0] out;
    logic        done;
    logic        busy;

    modport master (
        output in,
        output en,
        input  out,
        input  done,
        input  busy
    );

    modport slave (
        input  in,
        input  en,
        output out,
        output done,
        output busy
    );
endinterface

// File: rtl/k_8_square_seq.sv
// rtl/k_8_square_seq.sv - iterative shift-add FP16 squarer, truncating, flush-to-zero
module k_8_square_seq #(
    parameter int EXP_BIAS = 15,
    parameter bit SAT_OVF  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    k_8_square_seq_if.slave  io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] opnd_q, opnd_d;
    logic [21:0] p_q, p_d;
    logic [15:0] out_q, out_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [4:0]         exp_in;
    logic [10:0]        mcand;
    logic [15:0]        mbits;
    logic [21:0]        p_inc;
    logic signed [6:0]  exp_base;
    logic signed [6:0]  exp_n;
    logic [9:0]         mant;
    logic [15:0]        result;

    assign exp_in = opnd_q[14:10];
    assign mcand  = {1'b1, opnd_q[9:0]};
    assign mbits  = {5'b0, mcand};
    assign p_inc  = {11'b0, mcand} << cnt_q;

    // Squaring two values in [1,2) lands in [1,4); P[21] marks the [2,4) half.
    always_comb begin
        exp_base = $signed({1'b0, exp_in, 1'b0}) - $signed(7'(EXP_BIAS));
        exp_n    = p_q[21] ? exp_base + 7'sd1 : exp_base;
        mant     = p_q[21] ? p_q[20:11] : p_q[19:10];
        if (exp_in == 5'd0)
            result = 16'h0000;
        else if (exp_in == 5'd31)
            result = 16'h7C00;
        else if (exp_n > 7'sd30)
            result = SAT_OVF ? 16'h7BFF : 16'h7C00;
        else if (exp_n < 7'sd1)
            result = 16'h0000;
        else
            result = {1'b0, exp_n[4:0], mant};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        p_d     = p_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = (state_q == S_MULT);
        case (state_q)
            S_IDLE: begin
                if (io.en) begin
                    opnd_d  = io.in;
                    p_d     = 22'd0;
                    cnt_d   = 4'd0;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                if (mbits[cnt_q])
                    p_d = p_q + p_inc;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10)
                    state_d = S_NORM;
            end
            S_NORM: begin
                out_d   = result;
                done_d  = 1'b1;
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            opnd_q  <= 16'h0000;
            p_q     <= 22'd0;
            out_q   <= 16'h0000;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            p_q     <= p_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign io.out  = out_q;
    assign io.done = done_q;
    assign io.busy = busy_q;
endmodule

// File: tb/tb_k_8_square_seq.sv
// tb/tb_k_8_square_seq.sv - directed and swept checks of the FP16 squarer, both overflow modes
module tb_k_8_square_seq;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    k_8_square_seq_if io1 ();
    k_8_square_seq_if io0 ();

    k_8_square_seq #(.EXP_BIAS(15), .SAT_OVF(1'b1)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .io  (io1.slave)
    );

    k_8_square_seq #(.EXP_BIAS(15), .SAT_OVF(1'b0)) u_dut_inf (
        .clk (clk),
        .rst (rst),
        .io  (io0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_sq(input logic [15:0] v, input bit sat);
        int e, m, p, ex, mt;
        e = int'(v[14:10]);
        m = int'(v[9:0]);
        if (e == 0) return 16'h0000;
        if (e == 31) return 16'h7C00;
        p  = (1024 + m) * (1024 + m);
        ex = 2 * e - 15;
        if (p >= (1 << 21)) begin
            ex = ex + 1;
            mt = (p / 2048) % 1024;
        end else begin
            mt = (p / 1024) % 1024;
        end
        if (ex > 30) return sat ? 16'h7BFF : 16'h7C00;
        if (ex < 1) return 16'h0000;
        return {1'b0, 5'(ex), 10'(mt)};
    endfunction

    task automatic set_in(input logic [15:0] v, input logic e);
        io1.in = v;
        io0.in = v;
        io1.en = e;
        io0.en = e;
    endtask

    task automatic do_op(input string tag, input logic [15:0] v, input logic [15:0] exp1,
                         input logic [15:0] exp0, input int inj_at, input logic [15:0] inj_v);
        int lat;
        int busy_n;
        bit got;
        @(negedge clk);
        set_in(v, 1'b1);
        @(posedge clk);
        #1;
        set_in(v, 1'b0);
        lat = 0;
        busy_n = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            if (inj_at != 0 && lat == inj_at - 1)
                set_in(inj_v, 1'b1);
            @(posedge clk);
            lat++;
            #1;
            io1.en = 1'b0;
            io0.en = 1'b0;
            if (io1.busy) busy_n++;
            if (io1.done) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd12);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd11);
        chk({tag, "_out_sat"}, {16'h0, io1.out}, {16'h0, exp1});
        chk({tag, "_out_inf"}, {16'h0, io0.out}, {16'h0, exp0});
    endtask

    initial begin
        int dn;
        logic [15:0] rv;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        set_in(16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {16'h0, io1.out}, 32'h0);
        chk("reset_done", {31'h0, io1.done}, 32'h0);
        chk("reset_busy", {31'h0, io1.busy}, 32'h0);
        rst = 1'b0;

        do_op("two", 16'h4000, 16'h4400, 16'h4400, 0, 16'h0);
        @(posedge clk);
        #1;
        chk("done_single_cycle", {31'h0, io1.done}, 32'h0);

        do_op("one_half", 16'h3E00, 16'h4080, 16'h4080, 0, 16'h0);
        do_op("neg_three", 16'hC200, 16'h4880, 16'h4880, 0, 16'h0);
        do_op("ovf_256", 16'h5C00, 16'h7BFF, 16'h7C00, 0, 16'h0);
        do_op("max_normal", 16'h5BFF, 16'h7BFE, 16'h7BFE, 0, 16'h0);
        do_op("e22_m0", 16'h5800, 16'h7400, 16'h7400, 0, 16'h0);
        do_op("underflow", 16'h0C00, 16'h0000, 16'h0000, 0, 16'h0);
        do_op("min_result", 16'h2000, 16'h0400, 16'h0400, 0, 16'h0);
        do_op("min_p21", 16'h2200, 16'h0880, 16'h0880, 0, 16'h0);
        do_op("e7_p21_zero", 16'h1E00, 16'h0000, 16'h0000, 0, 16'h0);
        do_op("zero", 16'h0000, 16'h0000, 16'h0000, 0, 16'h0);
        do_op("subnormal", 16'h03FF, 16'h0000, 16'h0000, 0, 16'h0);
        do_op("nan", 16'h7E00, 16'h7C00, 16'h7C00, 0, 16'h0);
        do_op("inf", 16'hFC00, 16'h7C00, 16'h7C00, 0, 16'h0);

        // en while busy must be dropped without touching the latched operand
        do_op("busy_ignore", 16'h4000, 16'h4400, 16'h4400, 5, 16'h4200);
        chk("b2b_done_high", {31'h0, io1.done}, 32'h1);
        do_op("back_to_back", 16'h4200, 16'h4880, 16'h4880, 0, 16'h0);
        dn = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (io1.done) dn++;
        end
        chk("no_extra_done", 32'(dn), 32'd0);

        @(negedge clk);
        set_in(16'h4000, 1'b1);
        @(posedge clk);
        #1;
        set_in(16'h4000, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out", {16'h0, io1.out}, 32'h0);
        chk("abort_busy", {31'h0, io1.busy}, 32'h0);
        chk("abort_done", {31'h0, io1.done}, 32'h0);
        rst = 1'b0;
        dn = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (io1.done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        do_op("after_abort", 16'h3E00, 16'h4080, 16'h4080, 0, 16'h0);

        for (int i = 0; i < 16; i++) begin
            rv = 16'($urandom);
            do_op($sformatf("sweep_%0d_%h", i, rv), rv, ref_sq(rv, 1'b1), ref_sq(rv, 1'b0), 0, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
